// File: rtl/lgn_inference_ctrl.sv
// lgn_inference_ctrl: loads a sample into the logic-gate net, captures its output and reports the argmax class by group popcount
module lgn_inference_ctrl #(
  parameter int IN_BITS = 16,
  parameter int DATA_W = 8,
  parameter int OUT_BITS = 15,
  parameter int NUM_CLASSES = 5,
  parameter int NET_LATENCY = 0,
  localparam int GROUP = OUT_BITS / NUM_CLASSES,
  localparam int CLS_W = NUM_CLASSES > 1 ? $clog2(NUM_CLASSES) : 1,
  localparam int SC_W = $clog2(GROUP + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [IN_BITS-1:0]  net_in,
  input  logic [OUT_BITS-1:0] net_out,
  output logic [CLS_W-1:0]    result_class,
  output logic [SC_W-1:0]     result_score,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy
);
  localparam int CHUNKS = IN_BITS / DATA_W;
  localparam int KW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam int ST_W = NET_LATENCY > 0 ? $clog2(NET_LATENCY + 1) : 1;
  typedef enum logic [1:0] {LOAD, SETTLE, SCORE, DONE} state_t;
  state_t state;
  logic [KW-1:0] k;
  logic [ST_W-1:0] cnt;
  logic [OUT_BITS-1:0] cap;
  logic [CLS_W-1:0] cls, best_cls;
  logic [SC_W-1:0] best_sc, pc;
  logic [GROUP-1:0] grp;
  assign grp = cap[cls*GROUP +: GROUP];
  always_comb begin
    pc = '0;
    for (int i = 0; i < GROUP; i++) pc = pc + SC_W'(grp[i]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      k <= '0;
      cnt <= '0;
      net_in <= '0;
      cap <= '0;
      cls <= '0;
      best_cls <= '0;
      best_sc <= '0;
      result_class <= '0;
      result_score <= '0;
      result_valid <= 1'b0;
      busy <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          net_in[k*DATA_W +: DATA_W] <= in_data;
          if (k == KW'(CHUNKS - 1)) begin
            k <= '0;
            in_ready <= 1'b0;
            busy <= 1'b1;
            state <= SETTLE;
          end else k <= k + 1'b1;
        end
        SETTLE: if (cnt == ST_W'(NET_LATENCY)) begin
          cnt <= '0;
          cap <= net_out;
          cls <= '0;
          state <= SCORE;
        end else cnt <= cnt + 1'b1;
        SCORE: begin
          if (cls == '0 || pc > best_sc) begin
            best_cls <= cls;
            best_sc <= pc;
          end
          if (cls == CLS_W'(NUM_CLASSES - 1)) state <= DONE;
          else cls <= cls + 1'b1;
        end
        DONE: if (!result_valid) begin
          result_valid <= 1'b1;
          result_class <= best_cls;
          result_score <= best_sc;
        end else if (result_ready) begin
          result_valid <= 1'b0;
          busy <= 1'b0;
          in_ready <= 1'b1;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_lgn_inference_ctrl.sv
// tb_lgn_inference_ctrl: randomized self-checking bench comparing the controller against an argmax popcount model
module tb_lgn_inference_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, rst2_n = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0, result_ready = 1'b0;
  logic [14:0] net_out = '0, net_out2 = '0;
  logic in_ready, result_valid, busy, in_ready2, result_valid2, busy2;
  logic [15:0] net_in, net_in2;
  logic [2:0] result_class, result_class2;
  logic [1:0] result_score, result_score2;
  int tests = 0, fails = 0;
  lgn_inference_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .net_in(net_in), .net_out(net_out), .result_class(result_class), .result_score(result_score),
    .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
  );
  lgn_inference_ctrl #(.NET_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .net_in(net_in2), .net_out(net_out2), .result_class(result_class2), .result_score(result_score2),
    .result_valid(result_valid2), .result_ready(result_ready), .busy(busy2)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [14:0] v, output int cls, output int sc);
    cls = 0;
    sc = -1;
    for (int c = 0; c < 5; c++) begin
      int p = $countones((v >> (c * 3)) & 15'h7);
      if (p > sc) begin
        sc = p;
        cls = c;
      end
    end
  endfunction
  task automatic run_sample(input logic [7:0] c0, input logic [7:0] c1, input logic [14:0] v, input int hold);
    int ec, es, n;
    model(v, ec, es);
    check("in_ready_load", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data = c0;
    step();
    in_data = c1;
    step();
    in_valid = 1'b0;
    net_out = v;
    check("net_in", 32'(net_in), {16'h0, c1, c0});
    check("in_ready_busy", 32'(in_ready), 0);
    check("busy", 32'(busy), 1);
    n = 0;
    while (!result_valid && n < 30) begin
      step();
      n++;
    end
    check("latency", n, 7);
    check("class", 32'(result_class), ec);
    check("score", 32'(result_score), es);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = 8'($urandom);
      step();
      check("hold_valid", 32'(result_valid), 1);
      check("hold_class", 32'(result_class), ec);
      check("hold_score", 32'(result_score), es);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_net_in", 32'(net_in), {16'h0, c1, c0});
    end
    in_valid = 1'b0;
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("consumed_valid", 32'(result_valid), 0);
    check("in_ready_back", 32'(in_ready), 1);
    check("busy_idle", 32'(busy), 0);
  endtask
  initial begin
    int ec, es, n;
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(result_valid), 0);
    check("rst_net_in", 32'(net_in), 0);
    check("rst_class", 32'(result_class), 0);
    check("rst_score", 32'(result_score), 0);
    run_sample(8'hA5, 8'h3C, 15'h31D9, 0);
    run_sample(8'h11, 8'h22, 15'h73FB, 5);
    run_sample(8'h5A, 8'hC3, 15'h0000, 1);
    in_valid = 1'b1;
    in_data = 8'($urandom);
    step();
    step();
    in_valid = 1'b0;
    net_out = 15'($urandom);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midscore_valid", 32'(result_valid), 0);
    check("midscore_busy", 32'(busy), 0);
    check("midscore_in_ready", 32'(in_ready), 1);
    check("midscore_net_in", 32'(net_in), 0);
    in_valid = 1'b1;
    in_data = 8'hEE;
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midload_net_in", 32'(net_in), 0);
    repeat (20) run_sample(8'($urandom), 8'($urandom), 15'($urandom), int'($urandom_range(0, 2)));
    rst2_n = 1'b1;
    step();
    in_valid = 1'b1;
    in_data = 8'h96;
    step();
    in_data = 8'h69;
    step();
    in_valid = 1'b0;
    check("lat2_net_in", 32'(net_in2), 32'h6996);
    net_out2 = 15'h0007;
    step();
    net_out2 = 15'h01C0;
    step();
    net_out2 = 15'h7000;
    step();
    net_out2 = 15'h7FFF;
    model(15'h7000, ec, es);
    n = 3;
    while (!result_valid2 && n < 40) begin
      step();
      n++;
    end
    check("lat2_latency", n, 9);
    check("lat2_class", 32'(result_class2), ec);
    check("lat2_score", 32'(result_score2), es);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("lat2_consumed", 32'(result_valid2), 0);
    check("lat2_in_ready", 32'(in_ready2), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
